// File: rtl/dffram_arb.sv
// dffram_arb: arbitrates two masters onto one 256x32 single-port DFFRAM
// (1-cycle read latency, byte write enables); ack returns one cycle after grant.
module dffram_arb #(
    parameter int AW = 8,
    parameter bit RR = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          p0_req,
    input  logic [3:0]    p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_ack,
    output logic [31:0]   p0_rdata,
    input  logic          p1_req,
    input  logic [3:0]    p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_ack,
    output logic [31:0]   p1_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_a,
    output logic [31:0]   ram_di,
    input  logic [31:0]   ram_do
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t        state;
    logic          owner;
    logic          last;
    logic [AW-1:0] a_hold;
    logic [31:0]   di_hold;

    logic          grant;
    logic          sel;
    logic [3:0]    sel_we;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        grant = 1'b0;
        sel   = 1'b0;
        if (state == IDLE && !RST)
            grant = p0_req || p1_req;
        if (p0_req && p1_req)
            sel = RR ? ~last : 1'b0;
        else
            sel = p1_req;
        sel_we    = sel ? p1_we    : p0_we;
        sel_addr  = sel ? p1_addr  : p0_addr;
        sel_wdata = sel ? p1_wdata : p0_wdata;
    end

    assign ram_en = grant;
    assign ram_we = grant ? sel_we : 4'b0000;
    assign ram_a  = grant ? sel_addr : a_hold;
    assign ram_di = grant ? sel_wdata : di_hold;

    // Ack decodes registered state only; RST masks it so a reset in RESP drops the ack.
    assign p0_ack   = (state == RESP) && !owner && !RST;
    assign p1_ack   = (state == RESP) && owner && !RST;
    assign p0_rdata = p0_ack ? ram_do : 32'h0;
    assign p1_rdata = p1_ack ? ram_do : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            a_hold  <= '0;
            di_hold <= '0;
        end else if (state == RESP) begin
            state <= IDLE;
        end else if (grant) begin
            state   <= RESP;
            owner   <= sel;
            last    <= sel;
            a_hold  <= sel_addr;
            di_hold <= sel_wdata;
        end
    end
endmodule

// File: tb/tb_dffram_arb.sv
// tb_dffram_arb: scoreboard bench; one round-robin and one fixed-priority arbiter,
// each with a behavioural RAM, checked against a word-array reference model.
module tb_dffram_arb;
    logic        clk;
    logic        rst;
    logic        mem_clr;
    logic        req   [4];
    logic [3:0]  we    [4];
    logic [7:0]  addr  [4];
    logic [31:0] wdata [4];
    wire  [3:0]  ack;
    wire  [31:0] rdata0, rdata1, rdata2, rdata3;

    wire         ram_en_r, ram_en_f;
    wire  [3:0]  ram_we_r, ram_we_f;
    wire  [7:0]  ram_a_r, ram_a_f;
    wire  [31:0] ram_di_r, ram_di_f;
    logic [31:0] ram_do_r, ram_do_f;
    logic [31:0] mem_r [256];
    logic [31:0] mem_f [256];

    typedef logic [31:0] word_q_t [$];
    word_q_t     exp_q [4];
    logic [31:0] ref_mem [2][256];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] rd;
    int          n;
    logic [1:0]  exp2;

    dffram_arb #(.AW(8), .RR(1'b1)) dut_rr (
        .CLK(clk), .RST(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p0_ack(ack[0]), .p0_rdata(rdata0),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_ack(ack[1]), .p1_rdata(rdata1),
        .ram_en(ram_en_r), .ram_we(ram_we_r), .ram_a(ram_a_r), .ram_di(ram_di_r),
        .ram_do(ram_do_r)
    );

    dffram_arb #(.AW(8), .RR(1'b0)) dut_fp (
        .CLK(clk), .RST(rst),
        .p0_req(req[2]), .p0_we(we[2]), .p0_addr(addr[2]), .p0_wdata(wdata[2]),
        .p0_ack(ack[2]), .p0_rdata(rdata2),
        .p1_req(req[3]), .p1_we(we[3]), .p1_addr(addr[3]), .p1_wdata(wdata[3]),
        .p1_ack(ack[3]), .p1_rdata(rdata3),
        .ram_en(ram_en_f), .ram_we(ram_we_f), .ram_a(ram_a_f), .ram_di(ram_di_f),
        .ram_do(ram_do_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DFFRAM: registered read of the old word, byte-masked write.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) mem_r[k] <= '0;
        end else if (ram_en_r) begin
            ram_do_r <= mem_r[ram_a_r];
            for (int b = 0; b < 4; b++)
                if (ram_we_r[b]) mem_r[ram_a_r][8*b +: 8] <= ram_di_r[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) mem_f[k] <= '0;
        end else if (ram_en_f) begin
            ram_do_f <= mem_f[ram_a_f];
            for (int b = 0; b < 4; b++)
                if (ram_we_f[b]) mem_f[ram_a_f][8*b +: 8] <= ram_di_f[8*b +: 8];
        end
    end

    function automatic logic [31:0] rdata_of(input int i);
        case (i)
            0:       return rdata0;
            1:       return rdata1;
            2:       return rdata2;
            default: return rdata3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int max);
        checks++;
        if (act > max) begin
            errors++;
            $display("FAIL %s: got %0d expected at most %0d", name, act, max);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected ack on index %0d: rdata %h with nothing pending", i, rdata_of(i));
                end else begin
                    check($sformatf("rdata idx%0d", i), rdata_of(i), exp_q[i].pop_front());
                end
            end else begin
                check($sformatf("rdata idle idx%0d", i), rdata_of(i), 32'h0);
            end
        end
        check("rr ram_en during ack", {31'b0, ram_en_r & (ack[0] | ack[1])}, 32'h0);
        check("fp ram_en during ack", {31'b0, ram_en_f & (ack[2] | ack[3])}, 32'h0);
    end

    // Reference model: expected ack data is the word before this access; writes merge bytes.
    task automatic push_exp(input int i, input logic [3:0] w, input logic [7:0] a, input logic [31:0] d);
        int inst = i / 2;
        exp_q[i].push_back(ref_mem[inst][a]);
        for (int b = 0; b < 4; b++)
            if (w[b]) ref_mem[inst][a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic drive(input int i, input logic r, input logic [3:0] w, input logic [7:0] a, input logic [31:0] d);
        req[i]   = r;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    task automatic wait_ack(input int i, output int cnt, output logic [31:0] data);
        cnt  = 0;
        data = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ack[i]) begin
                cnt  = c;
                data = rdata_of(i);
                break;
            end
        end
        if (cnt == 0) cnt = 99;
        @(posedge clk);
        #1;
        req[i] = 1'b0;
    endtask

    task automatic access(input int i, input logic [3:0] w, input logic [7:0] a, input logic [31:0] d,
                          input bit exact, input string name, output logic [31:0] data);
        int cnt;
        push_exp(i, w, a, d);
        drive(i, 1'b1, w, a, d);
        wait_ack(i, cnt, data);
        if (exact) check({name, " latency"}, cnt, 2);
        else       check_le({name, " latency"}, cnt, 4);
    endtask

    task automatic rand_access(input int i);
        logic [7:0]  a;
        logic [3:0]  w;
        logic [31:0] data;
        a = 8'(i * 32 + int'($urandom_range(0, 31)));
        w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        access(i, w, a, $urandom, 1'b0, $sformatf("rand p%0d", i), data);
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 4'h0, 8'h0, 32'h0);
        for (int k = 0; k < 256; k++) begin
            ref_mem[0][k] = '0;
            ref_mem[1][k] = '0;
        end
        rst     = 1'b1;
        mem_clr = 1'b1;

        // Reset with p0 already requesting a read of 0x05.
        push_exp(0, 4'h0, 8'h05, 32'h0);
        drive(0, 1'b1, 4'h0, 8'h05, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("reset ram_en", {31'b0, ram_en_r}, 32'h0);
        check("reset ram_we", {28'b0, ram_we_r}, 32'h0);
        check("reset ram_a", {24'b0, ram_a_r}, 32'h0);
        check("reset ram_di", ram_di_r, 32'h0);
        check("reset acks", {28'b0, ack}, 32'h0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        check("first grant ram_en", {31'b0, ram_en_r}, 32'h1);
        check("first grant ram_a", {24'b0, ram_a_r}, 32'h05);
        wait_ack(0, n, rd);
        check("first ack wait", n, 1);

        access(0, 4'hF, 8'h12, 32'hDEADBEEF, 1'b1, "p0 write", rd);
        access(0, 4'h0, 8'h12, 32'h0, 1'b1, "p0 read", rd);
        check("p0 read 0x12", rd, 32'hDEADBEEF);

        access(1, 4'hF, 8'h34, 32'h11223344, 1'b1, "p1 write full", rd);
        access(1, 4'h5, 8'h34, 32'hAABBCCDD, 1'b1, "p1 write bytes", rd);
        access(1, 4'h0, 8'h34, 32'h0, 1'b1, "p1 read", rd);
        check("p1 byte merge", rd, 32'h11BB33DD);

        // Round-robin: after a p0-only access, p1 wins the first conflict.
        access(0, 4'h0, 8'h12, 32'h0, 1'b1, "p0 solo", rd);
        push_exp(0, 4'h0, 8'h12, 32'h0);
        push_exp(0, 4'h0, 8'h12, 32'h0);
        push_exp(1, 4'h0, 8'h34, 32'h0);
        push_exp(1, 4'h0, 8'h34, 32'h0);
        drive(0, 1'b1, 4'h0, 8'h12, 32'h0);
        drive(1, 1'b1, 4'h0, 8'h34, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp2 = (k % 4 == 1) ? 2'b10 : (k % 4 == 3) ? 2'b01 : 2'b00;
            check($sformatf("rr ack order c%0d", k), {30'b0, ack[1], ack[0]}, {30'b0, exp2});
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, 4'h0, 8'h12, 32'h0);
        drive(1, 1'b0, 4'h0, 8'h34, 32'h0);

        // Fixed priority: p1 starves until p0 drops its request.
        for (int k = 0; k < 4; k++) push_exp(2, 4'h0, 8'h03, 32'h0);
        push_exp(3, 4'hF, 8'h07, 32'h5A5A5A5A);
        drive(2, 1'b1, 4'h0, 8'h03, 32'h0);
        drive(3, 1'b1, 4'hF, 8'h07, 32'h5A5A5A5A);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp2 = (k % 2 == 1) ? 2'b01 : 2'b00;
            check($sformatf("fp ack order c%0d", k), {30'b0, ack[3], ack[2]}, {30'b0, exp2});
        end
        @(posedge clk);
        #1;
        drive(2, 1'b0, 4'h0, 8'h03, 32'h0);
        @(negedge clk);
        check("fp p1 grant ram_en", {31'b0, ram_en_f}, 32'h1);
        check("fp p1 grant ram_a", {24'b0, ram_a_f}, 32'h07);
        check("fp p1 grant ram_we", {28'b0, ram_we_f}, 32'hF);
        check("fp p1 grant ram_di", ram_di_f, 32'h5A5A5A5A);
        wait_ack(3, n, rd);
        check("fp p1 ack wait", n, 1);
        access(3, 4'h0, 8'h07, 32'h0, 1'b1, "fp p1 read", rd);
        check("fp p1 read 0x07", rd, 32'h5A5A5A5A);

        // Reset during RESP suppresses the ack; the held request re-issues.
        push_exp(0, 4'h0, 8'h12, 32'h0);
        drive(0, 1'b1, 4'h0, 8'h12, 32'h0);
        @(negedge clk);
        check("rst-resp grant", {31'b0, ram_en_r}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst-resp ack suppressed", {31'b0, ack[0]}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ack(0, n, rd);
        check("rst-resp reissue wait", n, 2);
        check("rst-resp reissue data", rd, 32'hDEADBEEF);

        // Random traffic from both masters on disjoint address ranges.
        fork
            begin
                for (int t = 0; t < 40; t++) rand_access(0);
            end
            begin
                for (int t = 0; t < 40; t++) rand_access(1);
            end
        join

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            check($sformatf("pending idx%0d", i), exp_q[i].size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
